// File: rtl/seq_det_scheduler.sv
// seq_det_scheduler: one "11000" Mealy detector time-shared round-robin across NCH serial channels.
// Latency: bit accepted at edge N updates its context at N; det_valid/det_ch visible during cycle N+1.
// Backpressure: ch_ready is a combinational one-hot grant; det outputs are not flow-controlled.
// Optional per-channel detection counters: define SEQ_DET_PERCH_CNT_EN (otherwise det_cnt is tied to 0).
module seq_det_scheduler #(
  parameter int NCH   = 4,
  parameter int CW    = $clog2(NCH),
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NCH-1:0]     ch_valid,
  input  logic [NCH-1:0]     ch_bit,
  output logic [NCH-1:0]     ch_ready,
  input  logic [NCH-1:0]     flush,
  output logic               det_valid,
  output logic [CW-1:0]      det_ch,
  output logic [CNT_W-1:0]   det_total,
  output logic [NCH*8-1:0]   det_cnt
);

  // Saved detector contexts: progress through "11000"
  localparam logic [2:0] S0 = 3'b000;  // idle
  localparam logic [2:0] S1 = 3'b001;  // "1"
  localparam logic [2:0] S2 = 3'b010;  // "11"
  localparam logic [2:0] S3 = 3'b011;  // "110"
  localparam logic [2:0] S4 = 3'b100;  // "1100"

  logic [2:0]     ctx [NCH];
  logic [CW-1:0]  rr_ptr;
  logic [NCH-1:0] elig;
  logic           gnt_any;
  logic [CW-1:0]  gnt_idx;
  logic [2:0]     cur_ctx;
  logic [2:0]     nxt_ctx;
  logic           cur_bit;
  logic           hit;

  // A flushed channel is never granted, so flush and advance never collide on one context.
  assign elig = ch_valid & ~flush & {NCH{en}};

  // Round-robin search for the first eligible channel starting at rr_ptr, wrapping at NCH-1.
  always_comb begin
    int idx;
    logic [CW-1:0] cidx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cidx    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      cidx = idx[CW-1:0];
      if (!gnt_any && elig[cidx]) begin
        gnt_any = 1'b1;
        gnt_idx = cidx;
      end
    end
  end

  // One-hot grant decode.
  always_comb begin
    ch_ready = '0;
    if (gnt_any) ch_ready[gnt_idx] = 1'b1;
  end

  assign cur_ctx = ctx[gnt_idx];
  assign cur_bit = ch_bit[gnt_idx];

  // Shared engine: advance the granted context by one bit; illegal codes behave as idle.
  always_comb begin
    nxt_ctx = S0;
    hit     = 1'b0;
    case (cur_ctx)
      S1: nxt_ctx = cur_bit ? S2 : S0;
      S2: nxt_ctx = cur_bit ? S2 : S3;
      S3: nxt_ctx = cur_bit ? S1 : S4;
      S4: begin
        nxt_ctx = cur_bit ? S1 : S0;
        hit     = gnt_any & ~cur_bit;
      end
      default: nxt_ctx = cur_bit ? S1 : S0;
    endcase
  end

  // Context write-back: flush clears, otherwise only the granted channel moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) ctx[i] <= S0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i])                           ctx[i] <= S0;
        else if (gnt_any && gnt_idx == CW'(i))  ctx[i] <= nxt_ctx;
      end
    end
  end

  // Pointer moves just past the last granted channel; held when nothing is granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rr_ptr <= '0;
    else if (gnt_any) rr_ptr <= (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
  end

  // Detection reporting: one-cycle pulse, sticky channel index, saturating total.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_valid <= 1'b0;
      det_ch    <= '0;
      det_total <= '0;
    end else begin
      det_valid <= hit;
      if (hit) det_ch <= gnt_idx;
      if (hit && det_total != {CNT_W{1'b1}}) det_total <= det_total + 1'b1;
    end
  end

`ifdef SEQ_DET_PERCH_CNT_EN
  logic [7:0] cnt [NCH];

  // Per-channel saturating detection counters, cleared by flush of that channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i])
          cnt[i] <= '0;
        else if (hit && gnt_idx == CW'(i) && cnt[i] != 8'hFF)
          cnt[i] <= cnt[i] + 8'd1;
      end
    end
  end

  // Pack counters, channel 0 in the LSBs.
  always_comb begin
    det_cnt = '0;
    for (int i = 0; i < NCH; i++) det_cnt[8*i +: 8] = cnt[i];
  end
`else
  assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// tb_seq_det_scheduler: table vectors, directed multi-cycle sequences and random traffic
// checked against a history-based reference model of the "11000" detector and round-robin arbiter.
`timescale 1ns/1ps
module tb_seq_det_scheduler;
  localparam int NCH   = 4;
  localparam int CW    = 2;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [NCH-1:0]   ch_valid = '0;
  logic [NCH-1:0]   ch_bit = '0;
  logic [NCH-1:0]   flush = '0;
  logic [NCH-1:0]   ch_ready;
  logic             det_valid;
  logic [CW-1:0]    det_ch;
  logic [CNT_W-1:0] det_total;
  logic [NCH*8-1:0] det_cnt;

  seq_det_scheduler #(.NCH(NCH), .CW(CW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_valid(ch_valid), .ch_bit(ch_bit),
    .ch_ready(ch_ready), .flush(flush), .det_valid(det_valid), .det_ch(det_ch),
    .det_total(det_total), .det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bit history since the last clear, arbitration pointer, outputs.
  int          m_rr;
  int          m_len  [NCH];
  logic [4:0]  m_hist [NCH];
  int          m_cnt  [NCH];
  int          m_gnt;
  logic        m_dv;
  int          m_dch;
  int          m_total;

  // Values captured by the last cycle for directed/table checks.
  logic [NCH-1:0] rdy_s;
  logic           dv_s;
  logic [CW-1:0]  dch_s;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_dv = 1'b0; m_dch = 0; m_total = 0; m_gnt = -1;
    for (int i = 0; i < NCH; i++) begin
      m_len[i] = 0; m_hist[i] = '0; m_cnt[i] = 0;
    end
  endtask

  function automatic logic [63:0] exp_cnt();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[8*i +: 8] = m_cnt[i][7:0];
    return r;
  endfunction

  task automatic model_grant();
    m_gnt = -1;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_rr + k) % NCH;
      if (m_gnt < 0 && en && ch_valid[c] && !flush[c]) m_gnt = c;
    end
  endtask

  task automatic model_update();
    m_dv = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (flush[i]) begin
        m_len[i] = 0; m_hist[i] = '0; m_cnt[i] = 0;
      end
    end
    if (m_gnt >= 0) begin
      m_hist[m_gnt] = {m_hist[m_gnt][3:0], ch_bit[m_gnt]};
      m_len[m_gnt]++;
      if (m_len[m_gnt] >= 5 && m_hist[m_gnt] == 5'b11000) begin
        m_dv = 1'b1;
        m_dch = m_gnt;
        m_len[m_gnt] = 0;
        if (m_total < 65535) m_total++;
`ifdef SEQ_DET_PERCH_CNT_EN
        if (m_cnt[m_gnt] < 255) m_cnt[m_gnt]++;
`endif
      end
      m_rr = (m_gnt + 1) % NCH;
    end
  endtask

  // One clock cycle: drive at negedge, check grant before the edge, check registers after it.
  task automatic cycle(input logic e, input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                       input logic [NCH-1:0] f);
    logic [NCH-1:0] er;
    en = e; ch_valid = v; ch_bit = b; flush = f;
    #1;
    model_grant();
    er = '0;
    if (m_gnt >= 0) er[m_gnt] = 1'b1;
    rdy_s = ch_ready;
    check("model_ch_ready", ch_ready, er);
    @(posedge clk);
    model_update();
    @(negedge clk);
    dv_s = det_valid; dch_s = det_ch;
    check("model_det_valid", det_valid, m_dv);
    if (m_dv) check("model_det_ch", det_ch, m_dch);
    check("model_det_total", det_total, m_total);
    check("model_det_cnt", det_cnt, exp_cnt());
  endtask

  task automatic do_reset();
    en = 1'b0; ch_valid = '0; ch_bit = '0; flush = '0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("reset_det_valid", det_valid, 0);
    check("reset_det_ch", det_ch, 0);
    check("reset_det_total", det_total, 0);
    check("reset_det_cnt", det_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic           e;
    logic [NCH-1:0] v, b, f, rdy;
    logic           dv;
    logic [CW-1:0]  dch;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic e, input logic [3:0] v, input logic [3:0] b, input logic [3:0] f,
                     input logic [3:0] rdy, input logic dv, input logic [1:0] dch);
    vec_t t;
    t.e = e; t.v = v; t.b = b; t.f = f; t.rdy = rdy; t.dv = dv; t.dch = dch;
    tbl.push_back(t);
  endtask

  logic pat5 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic pat6 [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic pat9 [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int npulse;
    int pulse_at;
    int n1;
    int n3;
    logic [NCH-1:0] b;
    logic [NCH-1:0] fl;
    int pulses[$];

    // Single-channel detection, idle, flush mid-pattern, en hold, flush of another channel, ch3.
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0);
    add(1, 4'b0011, 4'b0000, 4'b0010, 4'b0001, 0, 0);
    add(1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 0, 0);
    add(1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 0, 0);
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0);
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0);
    add(1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1, 3);
    add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 3);

    model_reset();
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      cycle(tbl[i].e, tbl[i].v, tbl[i].b, tbl[i].f);
      check($sformatf("tbl%0d_ch_ready", i), rdy_s, tbl[i].rdy);
      check($sformatf("tbl%0d_det_valid", i), dv_s, tbl[i].dv);
      check($sformatf("tbl%0d_det_ch", i), dch_s, tbl[i].dch);
    end
    check("tbl_det_total", det_total, 4);

    // All channels valid: grants rotate 0,1,2,3; ch0 detects on its 5th grant (cycle 16).
    do_reset();
    npulse = 0; pulse_at = -1;
    for (int c = 0; c < 20; c++) begin
      b = '0;
      if (c % 4 == 0 && c / 4 < 5) b[0] = pat5[c / 4];
      cycle(1'b1, 4'b1111, b, 4'b0000);
      check("rot_ch_ready", rdy_s, 4'b0001 << (c % 4));
      if (dv_s) begin npulse++; pulse_at = c; end
    end
    check("rot_pulses", npulse, 1);
    check("rot_det_cycle", pulse_at, 16);
    check("rot_det_ch", det_ch, 0);

    // ch1 and ch3 interleaved, each 111000.
    do_reset();
    n1 = 0; n3 = 0; pulses.delete();
    for (int c = 0; c < 12; c++) begin
      b = '0;
      if (n1 < 6) b[1] = pat6[n1];
      if (n3 < 6) b[3] = pat6[n3];
      cycle(1'b1, 4'b1010, b, 4'b0000);
      if (rdy_s[1]) n1++;
      if (rdy_s[3]) n3++;
      if (dv_s) pulses.push_back(int'(dch_s));
    end
    check("ilv_pulse_count", pulses.size(), 2);
    if (pulses.size() == 2) begin
      check("ilv_first_ch", pulses[0], 1);
      check("ilv_second_ch", pulses[1], 3);
    end
    check("ilv_det_total", det_total, 2);

    // Mismatch recovery on ch2.
    do_reset();
    npulse = 0; pulse_at = -1;
    for (int c = 0; c < 9; c++) begin
      b = '0;
      b[2] = pat9[c];
      cycle(1'b1, 4'b0100, b, 4'b0000);
      if (dv_s) begin npulse++; pulse_at = c; end
    end
    check("mis_pulses", npulse, 1);
    check("mis_det_cycle", pulse_at, 8);
    check("mis_det_ch", det_ch, 2);

    // Reset mid-pattern clears context and pointer.
    do_reset();
    cycle(1'b1, 4'b0100, 4'b0000, 4'b0000);
    cycle(1'b1, 4'b0001, 4'b0001, 4'b0000);
    cycle(1'b1, 4'b0001, 4'b0001, 4'b0000);
    cycle(1'b1, 4'b0001, 4'b0000, 4'b0000);
    do_reset();
    check("rst_total_zero", det_total, 0);
    npulse = 0;
    cycle(1'b1, 4'b0001, 4'b0000, 4'b0000);
    if (dv_s) npulse++;
    cycle(1'b1, 4'b0001, 4'b0000, 4'b0000);
    if (dv_s) npulse++;
    check("rst_ctx_cleared", npulse, 0);
    do_reset();
    cycle(1'b1, 4'b1111, 4'b0000, 4'b0000);
    check("rst_rr_ptr_zero", rdy_s, 4'b0001);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      b = NCH'($urandom);
      fl = '0;
      if ($urandom_range(0, 15) == 0) fl[$urandom_range(0, NCH-1)] = 1'b1;
      cycle(($urandom_range(0, 7) != 0), NCH'($urandom), b, fl);
    end

`ifdef SEQ_DET_PERCH_CNT_EN
    // 300 detections on ch1 saturate its counter at 255; flush clears it.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      b = '0;
      b[1] = pat5[c % 5];
      cycle(1'b1, 4'b0010, b, 4'b0000);
    end
    check("perch_sat", det_cnt[15:8], 255);
    check("perch_total", det_total, 300);
    cycle(1'b1, 4'b0010, 4'b0000, 4'b0010);
    check("perch_flush", det_cnt[15:8], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
